// File: rtl/switch_port.sv
// switch_port: CPU-readable input port for slide switches and push-buttons.
// Every raw input is synchronised and debounced. Accepted key presses set
// sticky event flags, and a CPU read clears them. Read word layout:
// {ev[3:0], 2'b00, sw[9:0]}.
module switch_port #(
    parameter  int DB_CYCLES = 50000,
    localparam int CW        = $clog2(DB_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  SW,
    input  logic [3:0]  KEY,
    input  logic        re,
    output logic [15:0] PORTout,
    output logic        irq
);

    localparam int NIN = 14;
    // Idle level of each input: switches off (0), keys released (1).
    localparam logic [NIN-1:0] IDLE_VAL = 14'h3C00;
    localparam logic [CW-1:0]  CNT_MAX  = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic [NIN-1:0] raw_s;
    logic [NIN-1:0] sync1_q;
    logic [NIN-1:0] sync2_q;
    logic [NIN-1:0] deb_q;
    logic [NIN-1:0] deb_d;
    logic [CW-1:0]  cnt_q [NIN];
    logic [CW-1:0]  cnt_d [NIN];
    logic [3:0]     ev_q;
    logic [3:0]     ev_d;
    logic [3:0]     press_s;

    assign raw_s = {KEY, SW};

    // Two-flop synchroniser for every raw input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= IDLE_VAL;
            sync2_q <= IDLE_VAL;
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
        end
    end

    // Per-input debounce: accept a new level only after it has held for
    // DB_CYCLES consecutive cycles; any matching cycle restarts the count.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NIN; i++) begin
            cnt_d[i] = CNT_ZERO;
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = CNT_ZERO;
            end else if (cnt_q[i] == CNT_MAX) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = CNT_ZERO;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Event flags: a read clears them, but a press accepted on the same
    // edge wins so that press is still pending for the next read.
    always_comb begin
        press_s = deb_q[13:10] & ~deb_d[13:10];
        if (re) begin
            ev_d = press_s;
        end else begin
            ev_d = ev_q | press_s;
        end
    end

    // Debounced levels, counters and event flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_q <= IDLE_VAL;
            ev_q  <= 4'h0;
            for (int i = 0; i < NIN; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            deb_q <= deb_d;
            ev_q  <= ev_d;
            for (int i = 0; i < NIN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign PORTout = {ev_q, 2'b00, deb_q[9:0]};
    assign irq     = |ev_q;

endmodule

// File: tb/tb_switch_port.sv
// Directed bench for switch_port: a table of vectors for the main behaviour,
// plus hand-written sequences for reset corner cases and the default-parameter
// instance.
module tb_switch_port;

    logic        clk;
    logic        reset;
    logic [9:0]  SW;
    logic [3:0]  KEY;
    logic        re;
    logic [15:0] PORTout;
    logic        irq;

    logic        reset_big;
    logic [9:0]  sw_big;
    logic [15:0] port_big;
    logic        irq_big;

    int errors;
    int checks;

    switch_port #(.DB_CYCLES(4)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .SW      (SW),
        .KEY     (KEY),
        .re      (re),
        .PORTout (PORTout),
        .irq     (irq)
    );

    switch_port u_big (
        .clk     (clk),
        .reset   (reset_big),
        .SW      (sw_big),
        .KEY     (4'hF),
        .re      (1'b0),
        .PORTout (port_big),
        .irq     (irq_big)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [9:0]  sw;
        logic [3:0]  key;
        logic        re;
        int          cyc;
        logic [15:0] port;
        logic        irq;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [15:0] act_port,
                         input logic [15:0] exp_port, input logic act_irq,
                         input logic exp_irq);
        checks++;
        if (act_port !== exp_port || act_irq !== exp_irq) begin
            errors++;
            $display("FAIL %s: PORTout=%h irq=%b, expected PORTout=%h irq=%b",
                     name, act_port, act_irq, exp_port, exp_irq);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b0;
        reset_big = 1'b0;
        SW        = 10'h3FF;
        KEY       = 4'h0;
        re        = 1'b0;
        sw_big    = 10'h000;

        // Reset held with every input active: outputs must stay clear.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("reset_hold", PORTout, 16'h0000, irq, 1'b0);
        end
        check("reset_big", port_big, 16'h0000, irq_big, 1'b0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_edge4", PORTout, 16'h0000, irq, 1'b0);
        @(negedge clk);
        check("post_reset_edge5", PORTout, 16'hF3FF, irq, 1'b1);

        // Clean restart with idle inputs.
        reset = 1'b0;
        SW    = 10'h000;
        KEY   = 4'hF;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_after_reset", PORTout, 16'h0000, irq, 1'b0);

        // sw, key, re, cycles, expected PORTout, expected irq
        tbl.push_back('{10'h001, 4'hF, 1'b0, 5,  16'h0000, 1'b0}); // not yet at edge 4
        tbl.push_back('{10'h001, 4'hF, 1'b0, 1,  16'h0001, 1'b0}); // accepted at edge 5
        tbl.push_back('{10'h009, 4'hF, 1'b0, 3,  16'h0001, 1'b0}); // 3-cycle bounce
        tbl.push_back('{10'h001, 4'hF, 1'b0, 3,  16'h0001, 1'b0});
        tbl.push_back('{10'h009, 4'hF, 1'b0, 3,  16'h0001, 1'b0});
        tbl.push_back('{10'h001, 4'hF, 1'b0, 8,  16'h0001, 1'b0}); // bounce never seen
        tbl.push_back('{10'h001, 4'hB, 1'b0, 5,  16'h0001, 1'b0}); // KEY2 press pending
        tbl.push_back('{10'h001, 4'hB, 1'b0, 1,  16'h4001, 1'b1}); // KEY2 press accepted
        tbl.push_back('{10'h001, 4'hB, 1'b1, 0,  16'h4001, 1'b1}); // during re cycle
        tbl.push_back('{10'h001, 4'hB, 1'b1, 1,  16'h0001, 1'b0}); // cleared by read
        tbl.push_back('{10'h001, 4'hF, 1'b0, 10, 16'h0001, 1'b0}); // release: no flag
        tbl.push_back('{10'h001, 4'hD, 1'b0, 6,  16'h2001, 1'b1}); // ev[1] set
        tbl.push_back('{10'h001, 4'hC, 1'b0, 5,  16'h2001, 1'b1}); // KEY0 one edge short
        tbl.push_back('{10'h001, 4'hC, 1'b1, 1,  16'h1001, 1'b1}); // set wins over clear
        tbl.push_back('{10'h001, 4'hC, 1'b0, 0,  16'h1001, 1'b1});
        tbl.push_back('{10'h001, 4'hC, 1'b1, 0,  16'h1001, 1'b1}); // next read sees it
        tbl.push_back('{10'h001, 4'hC, 1'b1, 1,  16'h0001, 1'b0});
        tbl.push_back('{10'h001, 4'hC, 1'b1, 1,  16'h0001, 1'b0}); // back-to-back read
        tbl.push_back('{10'h001, 4'hF, 1'b0, 10, 16'h0001, 1'b0});
        tbl.push_back('{10'h3FF, 4'hF, 1'b0, 6,  16'h03FF, 1'b0}); // simultaneous accept
        tbl.push_back('{10'h2AA, 4'hF, 1'b0, 6,  16'h02AA, 1'b0});

        @(negedge clk);
        for (int v = 0; v < tbl.size(); v++) begin
            SW  = tbl[v].sw;
            KEY = tbl[v].key;
            re  = tbl[v].re;
            if (tbl[v].cyc == 0) begin
                #1;
            end else begin
                repeat (tbl[v].cyc) @(negedge clk);
            end
            check($sformatf("vec%0d", v), PORTout, tbl[v].port, irq, tbl[v].irq);
        end
        re = 1'b0;

        // Reset in the middle of a KEY3 debounce, key kept pressed.
        @(negedge clk);
        KEY = 4'h7;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_immediate", PORTout, 16'h0000, irq, 1'b0);
        repeat (2) @(negedge clk);
        check("midreset_hold", PORTout, 16'h0000, irq, 1'b0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("midreset_edge4", PORTout, 16'h0000, irq, 1'b0);
        @(negedge clk);
        check("midreset_edge5", PORTout, 16'h82AA, irq, 1'b1);

        // Default DB_CYCLES instance.
        reset_big = 1'b1;
        repeat (3) @(negedge clk);
        sw_big = 10'h200;
        repeat (50001) @(negedge clk);
        check("big_edge50000", port_big, 16'h0000, irq_big, 1'b0);
        @(negedge clk);
        check("big_edge50001", port_big, 16'h0200, irq_big, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
